// File: rtl/conv_pkg.sv
// conv_pkg: shared instruction-bus layout, sequencer state encoding and idle instruction word
package conv_pkg;
   localparam int INST_W         = 39;
   localparam int INST_SRAM_PSUM = 38;
   localparam int INST_RELU      = 37;
   localparam int INST_ACC       = 36;
   localparam int INST_CEN_P     = 35;
   localparam int INST_WEN_P     = 34;
   localparam int INST_AP_MSB    = 33;
   localparam int INST_AP_LSB    = 20;
   localparam int INST_CEN_X     = 19;
   localparam int INST_WEN_X     = 18;
   localparam int INST_AX_MSB    = 17;
   localparam int INST_AX_LSB    = 7;
   localparam int INST_OFIFO_RD  = 6;
   localparam int INST_IFIFO_WR  = 5;
   localparam int INST_IFIFO_RD  = 4;
   localparam int INST_L0_RD     = 3;
   localparam int INST_L0_WR     = 2;
   localparam int INST_EXECUTE   = 1;
   localparam int INST_LOAD      = 0;
   localparam int AP_W           = INST_AP_MSB - INST_AP_LSB + 1;
   localparam int AX_W           = INST_AX_MSB - INST_AX_LSB + 1;
   // both memories disabled and write-protected, everything else low
   localparam logic [INST_W-1:0] INST_RST = 39'h0C_000C_0000;
   typedef enum logic [3:0] {
      S_IDLE, S_W_L0, S_W_LOAD, S_GAP, S_A_L0, S_EXEC,
      S_DRAIN, S_ACC, S_ACC_TAIL, S_ACC_OUT, S_DONE
   } state_t;
endpackage

// File: rtl/seq_phase_cnt.sv
// seq_phase_cnt: loadable down-counter with terminal-count flag, used for phase, kij and output counters
module seq_phase_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   input  logic         en,
   output logic [W-1:0] q,
   output logic         tc
);
   // clear beats load beats decrement; holds at zero
   always_ff @(posedge clk or posedge reset)
      if (reset) q <= '0;
      else if (clr) q <= '0;
      else if (ld) q <= ld_val;
      else if (en && q != '0) q <= q - 1'b1;
   assign tc = (q == '0);
endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: instruction sequencer driving the systolic core through all kij tiles and the accumulation read-out
module conv_seq_ctrl
   import conv_pkg::*;
#(
   parameter int ROW      = 8,
   parameter int COL      = 8,
   parameter int LEN_NIJ  = 36,
   parameter int LEN_ONIJ = 16,
   parameter int LEN_KIJ  = 9,
   parameter int XADDR_W  = 11,
   parameter int PADDR_W  = 14,
   parameter int W_BASE   = 1024,
   parameter int GAP_CYC  = 10,
   parameter int OIDX_W   = (LEN_ONIJ > 1) ? $clog2(LEN_ONIJ) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              relu_en,
   input  logic              ofifo_valid,
   output logic [INST_W-1:0] inst,
   output logic              busy,
   output logic              done,
   output logic              out_valid,
   output logic [OIDX_W-1:0] out_idx
);
   localparam int CW = 16;

   if (LEN_KIJ * LEN_ONIJ > 2 ** PADDR_W || W_BASE + LEN_KIJ * COL > 2 ** XADDR_W) begin : g_param_chk
      $error("conv_seq_ctrl: psum or xmem address space too small for the tile parameters");
   end

   state_t              state, nxt;
   logic [CW-1:0]       cnt_q, k_q, o_q, cnt_val;
   logic                cnt_tc, k_tc, o_tc;
   logic                cnt_ld, cnt_en, k_ld, k_en, o_ld, o_en;
   logic                drain_wr, x_rd;
   int                  ci, ki, oi;
   logic [XADDR_W-1:0]  ax;
   logic [PADDR_W-1:0]  ap;
   logic [INST_W-1:0]   ni;

   function automatic int plen(state_t s);
      return s == S_W_L0 ? COL : s == S_W_LOAD ? COL + ROW : s == S_GAP ? GAP_CYC :
             (s == S_A_L0 || s == S_EXEC) ? LEN_NIJ : s == S_DRAIN ? LEN_ONIJ :
             s == S_ACC ? LEN_KIJ : 1;
   endfunction

   seq_phase_cnt #(.W(CW)) u_cnt (
      .clk(clk), .reset(reset), .clr(abort), .ld(cnt_ld), .ld_val(cnt_val),
      .en(cnt_en), .q(cnt_q), .tc(cnt_tc)
   );
   seq_phase_cnt #(.W(CW)) u_k (
      .clk(clk), .reset(reset), .clr(abort), .ld(k_ld), .ld_val(CW'(LEN_KIJ - 1)),
      .en(k_en), .q(k_q), .tc(k_tc)
   );
   seq_phase_cnt #(.W(CW)) u_o (
      .clk(clk), .reset(reset), .clr(abort), .ld(o_ld), .ld_val(CW'(LEN_ONIJ - 1)),
      .en(o_en), .q(o_q), .tc(o_tc)
   );

   // next state; abort overrides every transition
   always_comb begin
      nxt = state;
      if (abort) nxt = S_IDLE;
      else case (state)
         S_IDLE:     nxt = start ? S_W_L0 : S_IDLE;
         S_W_L0:     nxt = cnt_tc ? S_W_LOAD : state;
         S_W_LOAD:   nxt = cnt_tc ? S_GAP : state;
         S_GAP:      nxt = cnt_tc ? S_A_L0 : state;
         S_A_L0:     nxt = cnt_tc ? S_EXEC : state;
         S_EXEC:     nxt = cnt_tc ? S_DRAIN : state;
         S_DRAIN:    nxt = (ofifo_valid && cnt_tc) ? (k_tc ? S_ACC : S_W_L0) : state;
         S_ACC:      nxt = cnt_tc ? S_ACC_TAIL : state;
         S_ACC_TAIL: nxt = S_ACC_OUT;
         S_ACC_OUT:  nxt = o_tc ? S_DONE : S_ACC;
         S_DONE:     nxt = S_IDLE;
         default:    nxt = S_IDLE;
      endcase
   end

   // counters count remaining cycles; indices are recovered as length-1-remaining
   always_comb begin
      cnt_ld  = nxt != state;
      cnt_val = CW'(plen(nxt) - 1);
      cnt_en  = !cnt_ld && (state != S_DRAIN || ofifo_valid);
      k_ld    = state == S_IDLE && nxt == S_W_L0;
      k_en    = state == S_DRAIN && nxt == S_W_L0;
      o_ld    = state == S_DRAIN && nxt == S_ACC;
      o_en    = state == S_ACC_OUT && nxt == S_ACC;
      ci      = plen(state) - 1 - int'(cnt_q);
      ki      = LEN_KIJ - 1 - int'(k_q);
      oi      = LEN_ONIJ - 1 - int'(o_q);
      ax      = XADDR_W'(state == S_W_L0 ? W_BASE + ki * COL + ci : ci);
      ap      = PADDR_W'(state == S_DRAIN ? ki * LEN_ONIJ + ci : ci * LEN_ONIJ + oi);
   end

   // instruction word for the current state, registered below
   always_comb begin
      drain_wr = state == S_DRAIN && ofifo_valid;
      x_rd     = state == S_W_L0 || state == S_A_L0;
      ni       = INST_RST;
      ni[INST_RELU]                  = relu_en && state != S_IDLE && state != S_DONE;
      ni[INST_SRAM_PSUM]             = state == S_ACC;
      ni[INST_ACC]                   = (state == S_ACC && ci != 0) || state == S_ACC_TAIL;
      ni[INST_CEN_P]                 = !(drain_wr || state == S_ACC);
      ni[INST_WEN_P]                 = !drain_wr;
      ni[INST_AP_MSB:INST_AP_LSB]    = (drain_wr || state == S_ACC) ? AP_W'(ap) : '0;
      ni[INST_CEN_X]                 = !x_rd;
      ni[INST_AX_MSB:INST_AX_LSB]    = x_rd ? AX_W'(ax) : '0;
      ni[INST_OFIFO_RD]              = drain_wr;
      ni[INST_L0_RD]                 = state == S_W_LOAD || state == S_EXEC;
      ni[INST_L0_WR]                 = x_rd;
      ni[INST_EXECUTE]               = state == S_EXEC;
      ni[INST_LOAD]                  = state == S_W_LOAD || state == S_EXEC;
   end

   // state register and registered outputs
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state     <= S_IDLE;
         inst      <= INST_RST;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_idx   <= '0;
      end else if (abort) begin
         state     <= S_IDLE;
         inst      <= INST_RST;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_idx   <= '0;
      end else begin
         state     <= nxt;
         inst      <= ni;
         busy      <= nxt != S_IDLE;
         done      <= state == S_DONE;
         out_valid <= state == S_ACC_OUT;
         out_idx   <= state == S_ACC_OUT ? OIDX_W'(oi) : '0;
      end
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: phase-level reference model of the tile sequence compared cycle by cycle against the sequencer
module tb_conv_seq_ctrl;
   localparam int ROW = 8, COL = 8, NIJ = 36, ONIJ = 16, LK = 9, W_BASE = 1024, GAP = 10;
   localparam int SR = 4, SC = 4, SN = 16, SO = 4, SK = 4;
   localparam logic [38:0] RST = 39'h0C_000C_0000;

   logic        clk = 0;
   logic        reset, start, abort, relu_en, ofifo_valid;
   logic [38:0] inst;
   logic        busy, done, out_valid;
   logic [3:0]  out_idx;
   logic        s_rst, s_start;
   logic [38:0] s_inst;
   logic        s_busy, s_done, s_ov;
   logic [1:0]  s_idx;
   int          nchk = 0, nerr = 0;
   bit          noise_on = 0;

   always #5 clk = ~clk;

   conv_seq_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .relu_en(relu_en),
      .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done),
      .out_valid(out_valid), .out_idx(out_idx)
   );

   conv_seq_ctrl #(.ROW(SR), .COL(SC), .LEN_NIJ(SN), .LEN_ONIJ(SO), .LEN_KIJ(SK)) dut_s (
      .clk(clk), .reset(s_rst), .start(s_start), .abort(1'b0), .relu_en(1'b0),
      .ofifo_valid(1'b1), .inst(s_inst), .busy(s_busy), .done(s_done),
      .out_valid(s_ov), .out_idx(s_idx)
   );

   function automatic logic [38:0] mk(input bit ps, rl, ac, cp, wp, input int ap,
                                      input bit cx, wx, input int ax, input bit ofr, lr, lw, ex, ld);
      logic [38:0] w;
      w = '0;
      w[38] = ps; w[37] = rl; w[36] = ac; w[35] = cp; w[34] = wp; w[33:20] = 14'(ap);
      w[19] = cx; w[18] = wx; w[17:7] = 11'(ax);
      w[6] = ofr; w[3] = lr; w[2] = lw; w[1] = ex; w[0] = ld;
      return w;
   endfunction

   function automatic logic [38:0] idle_w(input bit rl);
      return mk(0, rl, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tk();
      start = noise_on && ($urandom_range(0, 3) == 0);
      tick();
   endtask

   task automatic chk(input string nm, input logic [38:0] ei, input logic eb, ed, eov, input int eoi);
      nchk++;
      if (inst !== ei || busy !== eb || done !== ed || out_valid !== eov || (eov && out_idx !== 4'(eoi))) begin
         nerr++;
         $display("FAIL %s: got inst=%h busy=%b done=%b ov=%b idx=%0d, want inst=%h busy=%b done=%b ov=%b idx=%0d",
                  nm, inst, busy, done, out_valid, out_idx, ei, eb, ed, eov, eoi);
      end
   endtask

   task automatic chk_int(input string nm, input int got, input int want);
      nchk++;
      if (got != want) begin
         nerr++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   // vm: 0 ofifo_valid tied high, 1 toggling 1,0,1,0 in DRAIN, 2 random
   task automatic run(input int vm, input int abort_k, input int rst_o);
      bit rl, v;
      int w, ph;
      rl = 1'($urandom_range(0, 1));
      relu_en = rl;
      ofifo_valid = 1;
      start = 1;
      tick();
      chk("start", RST, 1, 0, 0, 0);
      for (int k = 0; k < LK; k++) begin
         for (int c = 0; c < COL; c++) begin
            tk(); chk("w_l0", mk(0, rl, 0, 1, 1, 0, 0, 1, W_BASE + k * COL + c, 0, 0, 1, 0, 0), 1, 0, 0, 0);
         end
         for (int c = 0; c < COL + ROW; c++) begin
            tk(); chk("w_load", mk(0, rl, 0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 0, 1), 1, 0, 0, 0);
         end
         for (int c = 0; c < GAP; c++) begin
            tk(); chk("gap", idle_w(rl), 1, 0, 0, 0);
         end
         for (int c = 0; c < NIJ; c++) begin
            tk(); chk("a_l0", mk(0, rl, 0, 1, 1, 0, 0, 1, c, 0, 0, 1, 0, 0), 1, 0, 0, 0);
         end
         for (int c = 0; c < NIJ; c++) begin
            if (k == abort_k && c == 5) begin
               abort = 1;
               tk();
               abort = 0;
               chk("abort", RST, 0, 0, 0, 0);
               return;
            end
            tk(); chk("exec", mk(0, rl, 0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 1, 1), 1, 0, 0, 0);
         end
         w = 0;
         ph = 0;
         while (w < ONIJ) begin
            v = vm == 0 ? 1'b1 : vm == 1 ? (ph % 2 == 0) : 1'($urandom_range(0, 1));
            ph++;
            ofifo_valid = v;
            tk();
            chk("drain", v ? mk(0, rl, 0, 0, 0, k * ONIJ + w, 1, 1, 0, 1, 0, 0, 0, 0) : idle_w(rl), 1, 0, 0, 0);
            if (v) w++;
         end
         ofifo_valid = vm == 0 ? 1'b1 : 1'($urandom_range(0, 1));
      end
      for (int o = 0; o < ONIJ; o++) begin
         for (int j = 0; j < LK; j++) begin
            if (o == rst_o && j == 4) begin
               #2 reset = 1;
               #1 chk("async_rst", RST, 0, 0, 0, 0);
               #3 reset = 0;
               return;
            end
            tk(); chk("acc", mk(1, rl, j > 0, 0, 1, j * ONIJ + o, 1, 1, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0);
         end
         tk(); chk("acc_tail", mk(0, rl, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0);
         tk(); chk("acc_out", idle_w(rl), 1, 0, 1, o);
      end
      tk(); chk("done", RST, 0, 1, 0, 0);
      start = 0;
      tick(); chk("idle_after", RST, 0, 0, 0, 0);
   endtask

   typedef struct {
      bit          st, ab, rl;
      bit          eb1;
      logic [38:0] ei1;
      bit          eb2;
      logic [38:0] ei2;
   } vec_t;

   initial begin
      #500000;
      $display("watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tv[4];
      int   n, last;
      bit   got;
      tv[0] = '{0, 0, 0, 0, RST, 0, RST};
      tv[1] = '{1, 1, 1, 0, RST, 0, RST};
      tv[2] = '{0, 1, 0, 0, RST, 0, RST};
      tv[3] = '{1, 0, 1, 1, RST, 1, mk(0, 1, 0, 1, 1, 0, 0, 1, 1024, 0, 0, 1, 0, 0)};
      reset = 1; s_rst = 1; start = 0; abort = 0; relu_en = 0; ofifo_valid = 1; s_start = 0;
      #3 chk("reset", RST, 0, 0, 0, 0);
      #9 reset = 0; s_rst = 0;
      tick(); chk("reset_idle", RST, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         start = tv[i].st; abort = tv[i].ab; relu_en = tv[i].rl;
         tick(); chk($sformatf("tv%0d_a", i), tv[i].ei1, tv[i].eb1, 0, 0, 0);
         start = 0; abort = 0;
         tick(); chk($sformatf("tv%0d_b", i), tv[i].ei2, tv[i].eb2, 0, 0, 0);
         abort = 1; tick(); abort = 0;
      end
      run(0, -1, -1);
      run(1, -1, -1);
      run(0, 4, -1);
      start = 0;
      run(2, -1, -1);
      noise_on = 1;
      run(2, -1, 2);
      noise_on = 0;
      start = 0;
      tick(); chk("post_rst", RST, 0, 0, 0, 0);
      run(0, -1, -1);
      s_start = 1;
      tick();
      s_start = 0;
      n = 0; last = -1; got = 0;
      while (!got && n < 1000) begin
         tick();
         n++;
         if (!s_inst[35] && !s_inst[34]) last = int'(s_inst[33:20]);
         if (s_done) got = 1;
      end
      chk_int("small_cycles", n, SK * (SC + (SC + SR) + GAP + 2 * SN + SO) + SO * (SK + 2) + 1);
      chk_int("small_last_wr", last, SK * SO - 1);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
